// File: rtl/fact_unit_responder_if.sv
// fact_unit_responder_if: register bus between the memory map and one
// factorial slot, plus the slot's completion interrupt line.
interface fact_unit_responder_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done_irq;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  done_irq
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output done_irq
    );
endinterface

// File: rtl/fact_unit_responder.sv
// fact_unit_responder: memory-mapped iterative N! accelerator, one slot.
// Define FACT_IRQ_EN to drive done_irq; otherwise software polls STATUS.
module fact_unit_responder #(
    parameter int unsigned MAX_N = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fact_unit_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_N4 = MAX_N[3:0];

    state_t      state_q;
    logic [3:0]  n_q;
    logic [3:0]  cnt_q;
    logic [31:0] acc_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        err_q;
    logic        busy_q;

    logic [1:0]  sel;
    logic        n_wr;
    logic        go_wr;
    logic        ack_wr;
    logic        idle_like;
    logic        start;
    logic        load_err;
    logic        mul_last;
    logic        done_set;
    logic [31:0] rdata_c;
    logic        unused_bits;

    assign sel       = bus.addr[3:2];
    assign n_wr      = bus.we && (sel == 2'd0);
    assign go_wr     = bus.we && (sel == 2'd1) && bus.wdata[0];
    assign ack_wr    = bus.we && (sel == 2'd2) && bus.wdata[0];
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign start     = go_wr && idle_like;
    assign load_err  = (state_q == LOAD) && (n_q > MAX_N4);
    assign mul_last  = (state_q == MUL) && (cnt_q <= 4'd1);
    assign done_set  = load_err || mul_last;

    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:4]};

    // Control FSM: operand capture, multiply loop and status flags.
    // The ack clear is placed first so a same-edge completion overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= 4'd0;
            cnt_q    <= 4'd0;
            acc_q    <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (ack_wr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (n_wr) begin
                        n_q <= bus.wdata[3:0];
                    end
                    if (start) begin
                        state_q <= LOAD;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    acc_q <= 32'd1;
                    cnt_q <= n_q;
                    if (load_err) begin
                        result_q <= 32'd0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= acc_q * {28'd0, cnt_q};
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency register read mux; GO and unused bits read as zero.
    always_comb begin
        rdata_c = 32'd0;
        unique case (sel)
            2'd0:    rdata_c = {28'd0, n_q};
            2'd2:    rdata_c = {29'd0, busy_q, err_q, done_q};
            2'd3:    rdata_c = result_q;
            default: rdata_c = 32'd0;
        endcase
    end

    assign bus.rdata = rdata_c;

`ifdef FACT_IRQ_EN
    logic irq_q;

    // Level interrupt tracking done: set on completion, dropped by ack or GO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (done_set) begin
            irq_q <= 1'b1;
        end else if (ack_wr || start) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.done_irq = irq_q;
`else
    assign bus.done_irq = 1'b0;
`endif

endmodule

// File: tb/tb_fact_unit_responder.sv
// tb_fact_unit_responder: directed and randomized checks of the factorial
// slot against a plain-arithmetic reference model.
module tb_fact_unit_responder;

    localparam int MAXN = 12;
`ifdef FACT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    fact_unit_responder_if bus();

    fact_unit_responder #(.MAX_N(MAXN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_fact(input int n);
        logic [31:0] r;
        if (n > MAXN) return 32'd0;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    function automatic int ref_lat(input int n);
        if (n > MAXN) return 1;
        return ((n < 1) ? 1 : n) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wait_done(output int lat);
        logic [31:0] s;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus_rd(32'h8, s);
            if (s[0]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_fact(input int n);
        logic [31:0] v;
        int lat;
        bus_wr(32'h0, 32'(n));
        bus_wr(32'h4, 32'h1);
        bus_rd(32'h8, v);
        chk($sformatf("busy_e0_n%0d", n), v, 32'h4);
        chk($sformatf("irq_e0_n%0d", n), {31'd0, bus.done_irq}, 32'd0);
        wait_done(lat);
        chk($sformatf("latency_n%0d", n), 32'(lat), 32'(ref_lat(n)));
        bus_rd(32'h8, v);
        chk($sformatf("status_n%0d", n), v, (n > MAXN) ? 32'h3 : 32'h1);
        bus_rd(32'hC, v);
        chk($sformatf("result_n%0d", n), v, ref_fact(n));
        chk($sformatf("irq_n%0d", n), {31'd0, bus.done_irq},
            {31'd0, IRQ_ON});
    endtask

    initial begin
        logic [31:0] v;
        int lat;
        int n;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        bus_rd(32'h0, v);
        chk("rst_n_reg", v, 32'd0);
        bus_rd(32'h4, v);
        chk("rst_go", v, 32'd0);
        bus_rd(32'h8, v);
        chk("rst_status", v, 32'd0);
        bus_rd(32'hC, v);
        chk("rst_result", v, 32'd0);
        chk("rst_irq", {31'd0, bus.done_irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_wr(32'h0, 32'hFFFF_FFF5);
        bus_rd(32'h0, v);
        chk("n_upper_bits", v, 32'd5);

        run_fact(5);
        run_fact(0);
        run_fact(1);
        run_fact(12);
        run_fact(13);

        bus_wr(32'h8, 32'h1);
        bus_rd(32'h8, v);
        chk("ack_status", v, 32'd0);
        chk("ack_irq", {31'd0, bus.done_irq}, 32'd0);

        bus_wr(32'hC, 32'hDEAD_BEEF);
        bus_rd(32'hC, v);
        chk("result_ro", v, 32'd0);
        bus_rd(32'h4, v);
        chk("go_reads0", v, 32'd0);

        bus_wr(32'h0, 32'd6);
        bus_wr(32'h4, 32'h1);
        bus_wr(32'h0, 32'd3);
        bus_wr(32'h4, 32'h1);
        bus_rd(32'hC, v);
        chk("result_held_busy", v, 32'd0);
        wait_done(lat);
        chk("busy_ignore_done", {31'd0, lat != 0}, 32'd1);
        bus_rd(32'hC, v);
        chk("busy_ignore_result", v, 32'd720);
        bus_rd(32'h0, v);
        chk("busy_ignore_n", v, 32'd6);

        bus_wr(32'h0, 32'd10);
        bus_wr(32'h4, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        bus_rd(32'h0, v);
        chk("midrst_n", v, 32'd0);
        bus_rd(32'h8, v);
        chk("midrst_status", v, 32'd0);
        bus_rd(32'hC, v);
        chk("midrst_result", v, 32'd0);
        chk("midrst_irq", {31'd0, bus.done_irq}, 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(32'h8, v);
        chk("midrst_no_done", v, 32'd0);
        chk("midrst_no_irq", {31'd0, bus.done_irq}, 32'd0);
        run_fact(4);

        bus_wr(32'h0, 32'd3);
        bus_wr(32'h4, 32'h1);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = 32'h8;
        bus.wdata = 32'h1;
        repeat (ref_lat(3)) @(posedge clk);
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
        bus_rd(32'h8, v);
        chk("ack_vs_set_status", v, 32'h1);
        bus_rd(32'hC, v);
        chk("ack_vs_set_result", v, 32'd6);
        chk("ack_vs_set_irq", {31'd0, bus.done_irq}, {31'd0, IRQ_ON});

        for (int i = 0; i < 12; i++) begin
            n = int'($urandom_range(0, 15));
            run_fact(n);
            bus_rd(32'h0, v);
            chk($sformatf("rnd_n_read_%0d", i), v, 32'(n));
            if ($urandom_range(0, 1) == 1) begin
                bus_wr(32'h8, 32'h1);
                bus_rd(32'h8, v);
                chk($sformatf("rnd_ack_%0d", i), v, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
